// File: rtl/seg_scan_pkg.sv
// Shared segment encodings for the multiplexed seven-segment scanner.
// Cathodes are active-low, bit 0 = segment a ... bit 6 = segment g.
package seg_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timing: phase sub-counter, brightness phase index and digit index.
// boundary is high in the cycle whose edge wraps the digit index back to 0.
module seg_scan_timer #(
    parameter int NUM_DIGITS = 8,
    parameter int PHASE_DIV  = 12500,
    parameter int BRIGHT_W   = 4,
    localparam int DIGIT_W   = $clog2(NUM_DIGITS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [DIGIT_W-1:0]  digit,
    output logic [BRIGHT_W-1:0] phase,
    output logic                boundary
);

    localparam int SUB_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

    logic [SUB_W-1:0] sub;
    logic             sub_wrap;
    logic             phase_wrap;

    assign sub_wrap   = (sub == SUB_W'(PHASE_DIV - 1));
    assign phase_wrap = sub_wrap && (phase == '1);
    assign boundary   = phase_wrap && (digit == DIGIT_W'(NUM_DIGITS - 1));

    // Phase index spans a full power of two, so it wraps on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub   <= '0;
            phase <= '0;
            digit <= '0;
        end else begin
            sub <= sub_wrap ? '0 : sub + 1'b1;
            if (sub_wrap)
                phase <= phase + 1'b1;
            if (phase_wrap)
                digit <= boundary ? '0 : digit + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// N-digit common-anode scanner with double-buffered digit banks, per-digit
// enables, leading-zero suppression and PWM brightness; all outputs registered.
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int PHASE_DIV  = 12500,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              CA,
    output logic                    DP,
    output logic                    frame_done
);

    localparam int DIGIT_W = $clog2(NUM_DIGITS);

    logic [DIGIT_W-1:0]  digit;
    logic [BRIGHT_W-1:0] phase;
    logic                boundary;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .PHASE_DIV  (PHASE_DIV),
        .BRIGHT_W   (BRIGHT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .digit    (digit),
        .phase    (phase),
        .boundary (boundary)
    );

    logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_en, act_en;
    logic                    pend_lz, act_lz;
    logic [BRIGHT_W-1:0]     pend_bright, act_bright;

    // A load landing on the boundary bypasses the pending bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_lz     <= 1'b0;
            pend_bright <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_en      <= '0;
            act_lz      <= 1'b0;
            act_bright  <= '0;
        end else begin
            if (load) begin
                pend_digits <= digits;
                pend_dp     <= dp;
                pend_en     <= digit_en;
                pend_lz     <= lz_blank;
                pend_bright <= brightness;
            end
            if (boundary) begin
                act_digits <= load ? digits     : pend_digits;
                act_dp     <= load ? dp         : pend_dp;
                act_en     <= load ? digit_en   : pend_en;
                act_lz     <= load ? lz_blank   : pend_lz;
                act_bright <= load ? brightness : pend_bright;
            end
        end
    end

    // chain stays high while every enabled digit above j is suppressed.
    logic [NUM_DIGITS-1:0] sup;
    always_comb begin
        logic chain;
        chain = 1'b1;
        sup   = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            sup[j] = act_lz && (j != 0) && (act_digits[4*j +: 4] == 4'h0)
                     && !act_dp[j] && chain;
            chain  = chain && (!act_en[j] || sup[j]);
        end
    end

    logic [3:0]            nib;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_next;

    assign nib = act_digits[{digit, 2'b00} +: 4];
    assign lit = act_en[digit] && !sup[digit] && (phase < act_bright);

    always_comb begin
        an_next        = '1;
        an_next[digit] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            AN         <= '1;
            CA         <= SEG_BLANK;
            DP         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (lit) begin
                AN <= an_next;
                CA <= hex_to_seg(nib);
                DP <= ~act_dp[digit];
            end else begin
                AN <= '1;
                CA <= SEG_BLANK;
                DP <= 1'b1;
            end
        end
    end

endmodule
